i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_slave : RIB-programmable 7-bit-address I2C slave, 2-byte TX/RX window |
// | Option I2C_SLAVE_GLITCH_FILTER_EN : 4-sample filter on synced scl/sda     |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module i2c_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        scl,
  inout  wire         sda
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        byte_idx, byte_idx_nxt;
  logic [6:0]  shift, shift_nxt;
  logic        sda_oe, sda_oe_nxt;
  logic        ack_on, ack_on_nxt;
  logic        rw, rw_nxt;
  logic [15:0] rx_data, rx_data_nxt;
  logic        rx_valid, rx_valid_nxt;
  logic [6:0]  slv_addr;
  logic [15:0] tx_data;
  logic        enable;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_f, sda_f, scl_d, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic        unused_bits;

  assign unused_bits = ^{addr_i[31:20], addr_i[15:0], data_i[31:16]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;
  logic       scl_flt, sda_flt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl_flt  <= scl_f;
      sda_flt  <= sda_f;
    end
  end

  // A new level is accepted once the current sample and the three before it agree.
  always_comb begin
    scl_f = scl_flt;
    sda_f = sda_flt;
    if (scl_hist == {3{scl_sync[1]}}) scl_f = scl_sync[1];
    if (sda_hist == {3{sda_sync[1]}}) sda_f = sda_sync[1];
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign tx_byte   = byte_idx ? tx_data[7:0] : tx_data[15:8];
  assign busy      = (state != IDLE);
  assign sda       = sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_idx_nxt = byte_idx;
    shift_nxt    = shift;
    sda_oe_nxt   = sda_oe;
    ack_on_nxt   = ack_on;
    rw_nxt       = rw;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = rx_valid;
    // Clear first so that a set later in this block wins.
    if (we_i && addr_i[19:16] == 4'd4 && data_i[2]) rx_valid_nxt = 1'b0;
    if (!enable || stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      ack_on_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt    = ADDR;
      bit_cnt_nxt  = 3'd0;
      byte_idx_nxt = 1'b0;
      sda_oe_nxt   = 1'b0;
      ack_on_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_nxt   = {shift[5:0], sda_f};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rw_nxt    = sda_f;
            state_nxt = (shift == slv_addr) ? ADDR_ACK : IDLE;
          end
        end
        // First fall starts driving the ACK, second fall ends it.
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          if (!ack_on) begin
            ack_on_nxt = 1'b1;
            sda_oe_nxt = 1'b1;
            if (state == RX_ACK && byte_idx) rx_valid_nxt = 1'b1;
          end else begin
            ack_on_nxt  = 1'b0;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            if (state == RX_ACK) byte_idx_nxt = ~byte_idx;
            if (state == ADDR_ACK && rw) begin
              state_nxt  = TX_BYTE;
              shift_nxt  = tx_byte[6:0];
              sda_oe_nxt = ~tx_byte[7];
            end else begin
              state_nxt = RX_BYTE;
            end
          end
        end
        RX_BYTE: if (scl_rise) begin
          shift_nxt   = {shift[5:0], sda_f};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = RX_ACK;
            if (byte_idx) rx_data_nxt[7:0]  = {shift, sda_f};
            else          rx_data_nxt[15:8] = {shift, sda_f};
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              shift_nxt  = tx_byte[6:0];
              sda_oe_nxt = ~tx_byte[7];
            end else begin
              shift_nxt  = {shift[5:0], 1'b0};
              sda_oe_nxt = ~shift[6];
            end
          end else if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nxt    = TX_ACK;
              byte_idx_nxt = ~byte_idx;
            end
          end
        end
        TX_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
          end else if (scl_rise) begin
            bit_cnt_nxt = 3'd0;
            state_nxt   = sda_f ? IDLE : TX_BYTE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      byte_idx <= 1'b0;
      shift    <= 7'd0;
      sda_oe   <= 1'b0;
      ack_on   <= 1'b0;
      rw       <= 1'b0;
      rx_data  <= 16'd0;
      rx_valid <= 1'b0;
      slv_addr <= 7'h48;
      tx_data  <= 16'd0;
      enable   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_idx <= byte_idx_nxt;
      shift    <= shift_nxt;
      sda_oe   <= sda_oe_nxt;
      ack_on   <= ack_on_nxt;
      rw       <= rw_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      if (we_i) begin
        case (addr_i[19:16])
          4'd1:    slv_addr <= data_i[6:0];
          4'd2:    tx_data  <= data_i[15:0];
          4'd4:    enable   <= data_i[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_o = 32'd0;
    if (rst_n) begin
      case (addr_i[19:16])
        4'd1:    data_o[6:0]  = slv_addr;
        4'd2:    data_o[15:0] = tx_data;
        4'd3:    data_o[15:0] = rx_data;
        4'd4:    data_o[2:0]  = {rx_valid, busy, enable};
        default: data_o = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// tb_i2c_slave : directed bit-banged I2C master plus RIB accesses; expected
// values are queued when stimulus is issued and popped when the DUT answers.
module tb_i2c_slave;
  localparam int Q = 10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        we_i  = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        scl   = 1'b1;
  logic        m_low = 1'b0;
  wire         sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  i2c_slave dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .scl    (scl),
    .sda    (sda)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic reg_wr(input logic [3:0] idx, input logic [31:0] d);
    @(negedge clk);
    we_i   = 1'b1;
    addr_i = {12'h0, idx, 16'h0};
    data_i = d;
    @(negedge clk);
    we_i   = 1'b0;
    data_i = 32'd0;
  endtask

  task automatic reg_chk(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    addr_i = {12'h0, idx, 16'h0};
    #1;
    check(tag, data_o);
  endtask

  task automatic sda_chk(input string tag, input logic exp);
    exp_q.push_back({31'd0, exp});
    check(tag, {31'd0, sda});
  endtask

  task automatic bus_start();
    m_low = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    m_low = 1'b1; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    m_low = 1'b0; tick(Q);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    m_low = ~b; tick(Q);
    scl   = 1'b1; tick(Q);
    s     = sda; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rb;
    logic [7:0] gbyte;
    gbyte = 8'hA5;

    // Reset state
    #2 rst_n = 1'b0;
    tick(3);
    reg_chk("data_o_in_reset", 4'd1, 32'h0);
    sda_chk("sda_in_reset", 1'b1);
    rst_n = 1'b1;
    tick(2);
    reg_chk("slv_addr_rst", 4'd1, 32'h48);
    reg_chk("tx_data_rst",  4'd2, 32'h0);
    reg_chk("rx_data_rst",  4'd3, 32'h0);
    reg_chk("ctrl_rst",     4'd4, 32'h0);
    reg_chk("unmapped_rd",  4'd7, 32'h0);

    // Write transfer
    reg_wr(4'd4, 32'h1);
    bus_start();
    exp_q.push_back(32'h0); wr_byte(8'h90, ack); check("wr_addr_ack", {31'd0, ack});
    exp_q.push_back(32'h0); wr_byte(8'hA5, ack); check("wr_b0_ack",   {31'd0, ack});
    exp_q.push_back(32'h0); wr_byte(8'h3C, ack); check("wr_b1_ack",   {31'd0, ack});
    reg_chk("ctrl_busy_rxv", 4'd4, 32'h7);
    bus_stop();
    tick(4);
    reg_chk("rx_data_wr",   4'd3, 32'hA53C);
    reg_chk("ctrl_after_wr", 4'd4, 32'h5);
    reg_wr(4'd4, 32'h5);
    reg_chk("rxv_cleared",  4'd4, 32'h1);

    // Read transfer, ACK then NACK
    reg_wr(4'd2, 32'h1234);
    bus_start();
    exp_q.push_back(32'h0);  wr_byte(8'h91, ack); check("rd_addr_ack", {31'd0, ack});
    exp_q.push_back(32'h12); rd_byte(1'b0, rb);   check("rd_byte0",    {24'd0, rb});
    exp_q.push_back(32'h34); rd_byte(1'b1, rb);   check("rd_byte1",    {24'd0, rb});
    sda_chk("sda_after_nack", 1'b1);
    reg_chk("idle_after_nack", 4'd4, 32'h1);
    bus_stop();

    // Address mismatch
    bus_start();
    exp_q.push_back(32'h1); wr_byte(8'hA0, ack); check("mismatch_noack", {31'd0, ack});
    reg_chk("mismatch_idle", 4'd4, 32'h1);
    reg_chk("mismatch_rx",   4'd3, 32'hA53C);
    bus_stop();

    // Repeated start
    bus_start();
    exp_q.push_back(32'h0); wr_byte(8'h90, ack); check("rs_waddr_ack", {31'd0, ack});
    exp_q.push_back(32'h0); wr_byte(8'h55, ack); check("rs_b0_ack",    {31'd0, ack});
    bus_start();
    exp_q.push_back(32'h0);  wr_byte(8'h91, ack); check("rs_raddr_ack", {31'd0, ack});
    exp_q.push_back(32'h12); rd_byte(1'b1, rb);   check("rs_rd_byte",   {24'd0, rb});
    bus_stop();
    tick(4);
    reg_chk("rs_rx_data", 4'd3, 32'h553C);
    reg_chk("rs_ctrl",    4'd4, 32'h1);

    // TX_DATA written after the byte-0 load; wrap to byte 0 on the third byte
    bus_start();
    exp_q.push_back(32'h0); wr_byte(8'h91, ack); check("mid_addr_ack", {31'd0, ack});
    reg_wr(4'd2, 32'hABCD);
    exp_q.push_back(32'h12); rd_byte(1'b0, rb); check("mid_byte0", {24'd0, rb});
    exp_q.push_back(32'hCD); rd_byte(1'b0, rb); check("mid_byte1", {24'd0, rb});
    exp_q.push_back(32'hAB); rd_byte(1'b1, rb); check("wrap_byte", {24'd0, rb});
    bus_stop();

    // Enable cleared while the slave is driving a 0 data bit
    reg_wr(4'd2, 32'h0000);
    bus_start();
    exp_q.push_back(32'h0); wr_byte(8'h91, ack); check("dis_addr_ack", {31'd0, ack});
    exp_q.push_back(32'h0); bit_xfer(1'b1, s);   check("dis_bit7",     {31'd0, s});
    sda_chk("dis_driving", 1'b0);
    reg_wr(4'd4, 32'h0);
    tick(1);
    sda_chk("dis_released", 1'b1);
    reg_chk("dis_ctrl", 4'd4, 32'h0);
    bus_stop();
    reg_wr(4'd4, 32'h1);

    // Reset asserted while the slave drives the address ACK
    reg_wr(4'd2, 32'h5A5A);
    bus_start();
    for (int i = 7; i >= 0; i--) bit_xfer(gbyte[i] ^ gbyte[i] ^ (8'h90 >> i), s);
    m_low = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_chk("ack_before_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sda_chk("sda_at_rst", 1'b1);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    reg_chk("tx_after_rst",   4'd2, 32'h0);
    reg_chk("rx_after_rst",   4'd3, 32'h0);
    reg_chk("ctrl_after_rst", 4'd4, 32'h0);
    reg_chk("addr_after_rst", 4'd1, 32'h48);

    // One-clk low pulse on scl during the first data bit of a write
    reg_wr(4'd4, 32'h1);
    bus_start();
    exp_q.push_back(32'h0); wr_byte(8'h90, ack); check("gl_addr_ack", {31'd0, ack});
    for (int i = 7; i >= 0; i--) begin
      m_low = ~gbyte[i]; tick(Q);
      scl   = 1'b1;
      if (i == 7) begin
        tick(3); scl = 1'b0; tick(1); scl = 1'b1; tick(Q - 4);
      end else begin
        tick(Q);
      end
      if (i == 0) begin
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        exp_q.push_back(32'h1);
`else
        exp_q.push_back(32'h0);
`endif
        check("gl_last_bit", {31'd0, sda});
      end
      tick(Q);
      scl = 1'b0; tick(Q);
    end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_q.push_back(32'h0);
`else
    exp_q.push_back(32'h1);
`endif
    bit_xfer(1'b1, ack); check("gl_ack", {31'd0, ack});
    bus_stop();
    tick(4);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    reg_chk("gl_rx_data", 4'd3, 32'hA500);
`else
    reg_chk("gl_rx_data", 4'd3, 32'hD200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
